mod_instruction_fetch: RTL
==========================

// Module: mod_instruction_fetch
// PURPOSE
//  Fetch stage upstream of the instruction ROM. Holds the PC and drives the ROM word
//  address. Captures the combinational ROM output into an IF/ID register with a valid
//  flag for decode. Handles decode stalls and taken-branch redirects, and halts fetch
//  when the ROM raises mem_end.
// PARAMETERS
//  PC_RESET  30'd0  word address fetched first after reset
//  ADDR_W    30     word-address width; must match ROM address port
//  INSTR_W   32     instruction width
// PORTS
//  clk             in   1        rising-edge clock
//  rst_n           in   1        synchronous active-low reset
//  rom_address     out  ADDR_W   word address to ROM; equals PC register
//  rom_instruction in   INSTR_W  combinational ROM data for rom_address
//  rom_mem_end     in   1        ROM flag: rom_address is past end of program
//  stall           in   1        decode not ready; hold IF/ID and PC
//  branch_taken    in   1        redirect PC this cycle
//  branch_target   in   ADDR_W   redirect word address
//  if_instruction  out  INSTR_W  IF/ID instruction
//  if_pc           out  ADDR_W   word address of if_instruction
//  if_pc_plus1     out  ADDR_W   if_pc+1, modulo 2^ADDR_W
//  if_valid        out  1        IF/ID holds a real instruction
//  fetch_halted    out  1        1 in HALTED state
//  perf_fetched    out  32       instructions delivered (optional feature)
//  perf_stalls     out  32       stall cycles (optional feature)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge, any state, mid-stream too): pc<=PC_RESET, if_* <=0,
//   if_valid<=0, state<=RUN, perf counters<=0. rom_address is combinational from pc.
//  States: RUN, HALTED. Priority per cycle: reset > branch_taken > stall > normal.
//  RUN, normal, rom_mem_end=0: if_instruction<=rom_instruction, if_pc<=pc,
//   if_valid<=1, pc<=pc+1. Latency: address to IF/ID is 1 cycle.
//  RUN, rom_mem_end=1, no branch: nothing captured. if_valid<=0, pc holds,
//   state<=HALTED. stall does not delay halt entry.
//  stall=1, no branch: pc, if_* and if_valid all hold. rom_address is unchanged.
//  branch_taken=1, any state and regardless of stall: pc<=branch_target,
//   if_valid<=0 (one bubble), state<=RUN. if_instruction/if_pc may hold stale data.
//  HALTED: pc holds, if_valid=0, fetch_halted=1. Only branch or reset leaves it.
//  pc increment wraps 2^ADDR_W-1 -> 0. There is no other range check; only the ROM
//   decides the end of program.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - perf_fetched increments on each cycle if_valid is loaded with 1.
//   - perf_stalls increments on each RUN cycle with stall=1 and branch_taken=0.
//   - Both are 32-bit saturating and cleared by reset.
//  Not defined: counters are not built and both ports are tied to 0.
// TESTING (ROM loaded with the standard 34-word test program; PC_RESET=0)
//  1. Release reset, no stall/branch -> cycle 1: if_valid=1, if_pc=0,
//     if_instruction=32'h04000001; cycle 3: if_pc=2, if_instruction=32'h04020003.
//  2. Free-run to pc=34 -> rom_mem_end=1, next cycle fetch_halted=1, if_valid=0,
//     rom_address stays 34; last valid if_pc=33.
//  3. Assert stall 3 cycles while rom_address=5 -> if_pc=4 and if_instruction held,
//     rom_address=5 throughout; resumes with if_pc=5.
//  4. branch_taken=1, target=2 at rom_address=10, stall=1 same cycle -> next cycle
//     if_valid=0, rom_address=2; following cycle if_instruction=32'h04020003.
//  5. In HALTED, branch target=0 -> state RUN, if_instruction=32'h04000001 two
//     cycles later. Reset at pc=20 -> next cycle rom_address=0, if_valid=0.
//  6. FETCH_PERF_CNT_EN set, run test 3 then halt -> perf_stalls=3, perf_fetched=34.
//     Without the macro both ports read 0.

Source files
------------

// File: rtl/mod_instruction_fetch.sv
// Fetch stage: holds the PC, drives the ROM word address, and registers ROM data into IF/ID.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module mod_instruction_fetch #(
  parameter int unsigned ADDR_W   = 30,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int unsigned INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  input  logic               rom_mem_end,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic               if_valid,
  output logic               fetch_halted,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stalls
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic               if_valid_q, if_valid_d;
  logic               capture;
  logic               stall_cycle;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    if_valid_d  = if_valid_q;
    capture     = 1'b0;
    stall_cycle = 1'b0;
    if (branch_taken) begin
      // Redirect wins over stall; the IF/ID slot becomes a bubble.
      pc_d       = branch_target;
      if_valid_d = 1'b0;
      state_d    = RUN;
    end else if (state_q == HALTED) begin
      if_valid_d = 1'b0;
    end else begin
      stall_cycle = stall;
      if (rom_mem_end) begin
        // Halt entry is not held off by stall.
        if_valid_d = 1'b0;
        state_d    = HALTED;
      end else if (!stall) begin
        capture    = 1'b1;
        if_instr_d = rom_instruction;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
        pc_d       = pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= PC_RESET;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign rom_address    = pc_q;
  assign if_instruction = if_instr_q;
  assign if_pc          = if_pc_q;
  assign if_pc_plus1    = if_pc_q + ADDR_W'(1);
  assign if_valid       = if_valid_q;
  assign fetch_halted   = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Saturating event counters.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stalls_d  = perf_stalls_q;
    if (capture && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 32'd1;
    if (stall_cycle && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalls  = perf_stalls_q;
`else
  logic unused_perf;
  assign unused_perf  = capture ^ stall_cycle;
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
`endif

endmodule
